// File: rtl/hps_tick_timer.sv
// Free-running timestamp with programmable prescaler, NUM_CMP compare channels,
// overflow pulse and a one-cycle-latency snapshot register.
module hps_tick_timer #(
  parameter int TIMER_W          = 32,
  parameter int PRESC_W          = 16,
  parameter int PRESCALE_DEFAULT = 5001,
  parameter int NUM_CMP          = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       presc_load,
  input  logic [PRESC_W-1:0]         presc_value,
  input  logic [NUM_CMP*TIMER_W-1:0] cmp_value,
  input  logic [NUM_CMP-1:0]         cmp_load,
  input  logic [NUM_CMP-1:0]         cmp_periodic,
  input  logic [NUM_CMP-1:0]         cmp_ack,
  input  logic                       snap_req,
  output logic [TIMER_W-1:0]         timer,
  output logic                       tick,
  output logic                       overflow,
  output logic [TIMER_W-1:0]         snapshot,
  output logic                       snap_valid,
  output logic [NUM_CMP-1:0]         cmp_flag
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [PRESC_W-1:0] divisor_q, divisor_d;
  logic [TIMER_W-1:0] timer_q, timer_d, timer_inc;
  logic [TIMER_W-1:0] snapshot_q, snapshot_d;
  logic               tick_q, tick_d;
  logic               overflow_q, overflow_d;
  logic               snap_valid_q, snap_valid_d;
  logic [NUM_CMP-1:0] cmp_flag_q, cmp_flag_d;
  logic [NUM_CMP-1:0] armed_q, armed_d;
  logic [TIMER_W-1:0] target_q [NUM_CMP];
  logic [TIMER_W-1:0] target_d [NUM_CMP];

  always_comb begin
    timer_inc = timer_q + TIMER_W'(1);
    // clear and presc_load both restart the prescale period, so they suppress a tick
    tick_d = enable && !clear && !presc_load &&
             (pcnt_q == divisor_q - PRESC_W'(1));
    overflow_d = tick_d && (&timer_q);

    pcnt_d = pcnt_q;
    if (clear || presc_load || tick_d)
      pcnt_d = '0;
    else if (enable)
      pcnt_d = pcnt_q + PRESC_W'(1);

    timer_d = timer_q;
    if (clear)
      timer_d = '0;
    else if (tick_d)
      timer_d = timer_inc;

    divisor_d = divisor_q;
    if (presc_load)
      divisor_d = (presc_value == '0) ? PRESC_W'(1) : presc_value;

    snapshot_d   = snap_req ? timer_q : snapshot_q;
    snap_valid_d = snap_req;

    armed_d    = armed_q;
    target_d   = target_q;
    cmp_flag_d = cmp_flag_q;
    for (int i = 0; i < NUM_CMP; i++) begin
      // a load discards any coincident match; a match beats a coincident ack
      if (cmp_load[i]) begin
        armed_d[i]  = 1'b1;
        target_d[i] = cmp_value[i*TIMER_W +: TIMER_W];
        if (cmp_ack[i])
          cmp_flag_d[i] = 1'b0;
      end else if (tick_d && armed_q[i] && (timer_inc == target_q[i])) begin
        cmp_flag_d[i] = 1'b1;
        if (cmp_periodic[i] && (cmp_value[i*TIMER_W +: TIMER_W] != '0))
          target_d[i] = target_q[i] + cmp_value[i*TIMER_W +: TIMER_W];
        else
          armed_d[i] = 1'b0;
      end else if (cmp_ack[i]) begin
        cmp_flag_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q       <= '0;
      divisor_q    <= PRESC_W'(PRESCALE_DEFAULT);
      timer_q      <= '0;
      tick_q       <= 1'b0;
      overflow_q   <= 1'b0;
      snapshot_q   <= '0;
      snap_valid_q <= 1'b0;
      cmp_flag_q   <= '0;
      armed_q      <= '0;
      for (int i = 0; i < NUM_CMP; i++)
        target_q[i] <= '0;
    end else begin
      pcnt_q       <= pcnt_d;
      divisor_q    <= divisor_d;
      timer_q      <= timer_d;
      tick_q       <= tick_d;
      overflow_q   <= overflow_d;
      snapshot_q   <= snapshot_d;
      snap_valid_q <= snap_valid_d;
      cmp_flag_q   <= cmp_flag_d;
      armed_q      <= armed_d;
      for (int i = 0; i < NUM_CMP; i++)
        target_q[i] <= target_d[i];
    end
  end

  assign timer      = timer_q;
  assign tick       = tick_q;
  assign overflow   = overflow_q;
  assign snapshot   = snapshot_q;
  assign snap_valid = snap_valid_q;
  assign cmp_flag   = cmp_flag_q;

endmodule

// File: doc/hps_tick_timer.md
Name: hps_tick_timer

Overview:
- Parametrised successor to the single fixed-divide HPS timer.
- Provides a free-running timestamp counter driven by a runtime-programmable prescaler, with enable and clear controls.
- Adds NUM_CMP compare channels (one-shot or periodic) with sticky flags, an overflow pulse and an atomic snapshot register.
- Sits in the GHRD fabric; HPS-visible registers (PIO/bridge) connect directly to its ports.

Parameters:
- TIMER_W, 32, width of timestamp counter and compare values.
- PRESC_W, 16, width of prescaler divisor and prescaler counter.
- PRESCALE_DEFAULT, 5001, divisor after reset (one tick every 5001 clk cycles); must be >= 1.
- NUM_CMP, 2, number of compare channels (1..8).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = prescaler runs; 0 = prescaler and timer hold.
- clear  in  1  pulse: zero prescaler counter and timer.
- presc_load  in  1  pulse: load presc_value as new divisor.
- presc_value  in  PRESC_W  new divisor; 0 is treated as 1.
- cmp_value  in  NUM_CMP*TIMER_W  per-channel compare value; channel i uses bits [i*TIMER_W +: TIMER_W].
- cmp_load  in  NUM_CMP  pulse: arm channel i, target <= cmp_value[i].
- cmp_periodic  in  NUM_CMP  1 = periodic re-arm; 0 = one-shot.
- cmp_ack  in  NUM_CMP  pulse: clear cmp_flag[i].
- snap_req  in  1  pulse: capture timer.
- timer  out  TIMER_W  current timestamp.
- tick  out  1  1-cycle pulse coincident with each timer increment.
- overflow  out  1  1-cycle pulse when timer wraps from all-ones to 0.
- snapshot  out  TIMER_W  captured timestamp.
- snap_valid  out  1  1-cycle pulse, snapshot updated.
- cmp_flag  out  NUM_CMP  sticky match flags.

Behaviour:
- Reset values: timer=0, pcnt=0, divisor=PRESCALE_DEFAULT, tick=0, overflow=0, snapshot=0, snap_valid=0, cmp_flag=0. All channels disarmed and all targets 0.
- Prescaler: when enable=1, pcnt counts 0..divisor-1.
  - At pcnt==divisor-1, pcnt<=0 and timer<=timer+1, with tick=1 on that same edge (registered; visible with the new timer value).
  - Divisor 1 gives a tick every enabled cycle.
  - With enable=0, pcnt and timer hold and tick=0.
- Wrap: timer is modulo 2^TIMER_W. The increment from all-ones to 0 asserts overflow together with tick.
- clear: pcnt<=0, timer<=0, no tick. Clear beats a coincident tick. Compare channels keep their armed state and targets.
- presc_load: divisor<=max(presc_value,1) and pcnt<=0 on the next edge. A coincident tick is suppressed. Combined with clear, both take effect.
- Compare, channel i:
  - cmp_load sets armed_i=1, target_i=cmp_value[i]. cmp_load takes effect even when enable=0.
  - On a tick edge where the new timer value equals target_i and armed_i=1, cmp_flag[i]<=1 on that same edge.
  - One-shot mode: armed_i<=0 after the match.
  - Periodic mode: target_i<=target_i+cmp_value[i] (mod 2^TIMER_W) and the channel stays armed. Periodic mode with cmp_value[i]==0 behaves as one-shot.
  - Matches are evaluated only at tick edges. A timer held at or cleared to a target value never matches.
  - cmp_ack clears the flag. A coincident match wins, so the flag stays 1.
  - cmp_load coincident with a match: the load wins and the match is dropped.
- Snapshot: snap_req at cycle n gives snapshot=timer value present at cycle n (pre-update), with snap_valid=1 at cycle n+1. Back-to-back requests each produce a pulse.
- Reset mid-count: everything returns to reset values on the next edge. Reset overrides all inputs.
- Latency summary: tick, overflow and cmp_flag are aligned to the timer edge; snapshot has 1-cycle latency.

Test Plan:
1. PRESCALE_DEFAULT=4, enable=1 for 20 cycles after reset -> tick pulses every 4th cycle, timer=5, overflow never set.
2. TIMER_W=8, divisor=1, timer cleared then run 256 cycles -> timer returns to 0 with overflow=1 and tick=1 on the same cycle; cmp_flag unaffected when channels are disarmed.
3. Channel 0 one-shot, cmp_value=3, divisor=2 -> cmp_flag[0]=1 on the edge timer becomes 3. After cmp_ack, no re-assert when timer later equals 3 again (no re-arm).
4. Channel 1 periodic, cmp_value=5, divisor=1 -> matches at timer=5,10,15. cmp_ack at the same cycle as the 10 match leaves the flag at 1.
5. At timer=7 mid-prescale, assert clear and presc_load(value 0) together -> timer=0, pcnt=0, divisor=1, no tick that cycle, ticks every cycle afterward.
6. snap_req while timer=12 on a tick edge -> snapshot=12 and snap_valid=1 one cycle later, timer already 13; reset asserted mid-run -> all outputs return to reset values next cycle.
